// File: rtl/ts_inject_mux_pkg.sv
// ts_inject_mux_pkg: shared TS constants and payload-path state encoding
package ts_inject_mux_pkg;
  localparam int PKT_WORDS = 48;
  localparam logic [12:0] NULL_PID = 13'h1FFF;
  localparam int PID_LSB = 8;
  localparam int PID_MSB = 20;
  typedef enum logic [2:0] {S_IDLE, S_MAIN, S_DROP, S_INJ_REQ, S_INJ} state_t;
endpackage

// File: rtl/ts_inject_mux_stat.sv
// ts_inject_mux_stat: wrapping packet/drop counters and single-cycle error pulses
module ts_inject_mux_stat
  import ts_inject_mux_pkg::*;
(
  input  logic        payload_clk,
  input  logic        payload_rst_n,
  input  logic        inj_done,
  input  logic        drop_done,
  input  logic        timeout,
  input  logic        len_bad,
  output logic [15:0] inj_pkt_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_timeout,
  output logic        err_len
);
  always_ff @(posedge payload_clk or negedge payload_rst_n)
    if (!payload_rst_n) begin
      inj_pkt_cnt <= 16'd0;
      drop_cnt <= 16'd0;
      err_timeout <= 1'b0;
      err_len <= 1'b0;
    end else begin
      inj_pkt_cnt <= inj_pkt_cnt + 16'(inj_done);
      drop_cnt <= drop_cnt + 16'(drop_done);
      err_timeout <= timeout;
      err_len <= len_bad;
    end
endmodule

// File: rtl/ts_inject_mux.sv
// ts_inject_mux: packet-boundary merge of inject PSI/SI packets into the main TS payload path
module ts_inject_mux
  import ts_inject_mux_pkg::*;
#(
  parameter int PAYLOAD_DATA_WIDTH = 32,
  parameter int PKT_WORDS = ts_inject_mux_pkg::PKT_WORDS,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                          payload_clk,
  input  logic                          payload_rst_n,
  input  logic                          main_valid,
  input  logic                          main_start,
  input  logic                          main_end,
  input  logic [PAYLOAD_DATA_WIDTH-1:0] main_data,
  output logic                          main_ready,
  input  logic                          inj_pending,
  output logic                          inj_req,
  input  logic                          inj_ack,
  input  logic                          inj_valid,
  input  logic                          inj_start,
  input  logic                          inj_end,
  input  logic [PAYLOAD_DATA_WIDTH-1:0] inj_data,
  input  logic [7:0]                    cfg_min_gap,
  input  logic                          cfg_null_drop,
  output logic                          out_valid,
  output logic                          out_start,
  output logic                          out_end,
  output logic [PAYLOAD_DATA_WIDTH-1:0] out_data,
  output logic [15:0]                   inj_pkt_cnt,
  output logic [15:0]                   drop_cnt,
  output logic                          err_timeout,
  output logic                          err_len
);
  state_t state, state_n;
  logic [7:0] gap_cnt, tmr, wcnt, wcnt_n;
  logic ack_seen, len_flag, inj_go, main_acc, inj_acc, from_main, fwd;
  logic inj_done, drop_done, timeout, len_bad, null_pkt;
  assign null_pkt = cfg_null_drop && main_data[PID_MSB:PID_LSB] == NULL_PID;
  assign inj_go = inj_pending && gap_cnt >= cfg_min_gap;
  assign main_ready = state == S_MAIN || state == S_DROP || (state == S_IDLE && main_valid && !main_start && !inj_go);
  assign inj_req = state == S_INJ_REQ || (state == S_INJ && !ack_seen);
  assign main_acc = main_valid && main_ready;
  assign inj_acc = inj_valid && (state == S_INJ || (state == S_INJ_REQ && inj_start));
  assign from_main = state == S_MAIN;
  assign fwd = (from_main && main_acc) || inj_acc;
  assign wcnt_n = state == S_INJ_REQ ? 8'd1 : wcnt == 8'hFF ? wcnt : wcnt + 8'd1;
  assign inj_done = inj_acc && inj_end;
  assign drop_done = state == S_DROP && main_acc && main_end;
  assign timeout = state == S_INJ_REQ && !inj_acc && tmr == 8'(REQ_TIMEOUT - 1);
  assign len_bad = inj_acc && !len_flag && (inj_end ? wcnt_n != 8'(PKT_WORDS) : wcnt_n > 8'(PKT_WORDS));
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = inj_go ? S_INJ_REQ : (main_valid && main_start) ? (null_pkt ? S_DROP : S_MAIN) : S_IDLE;
      S_MAIN, S_DROP: state_n = main_acc && main_end ? S_IDLE : state;
      S_INJ_REQ: state_n = inj_acc ? (inj_end ? S_IDLE : S_INJ) : timeout ? S_IDLE : S_INJ_REQ;
      S_INJ: state_n = inj_done ? S_IDLE : S_INJ;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge payload_clk or negedge payload_rst_n)
    if (!payload_rst_n) begin
      state <= S_IDLE;
      gap_cnt <= 8'hFF;
      tmr <= 8'd0;
      wcnt <= 8'd0;
      ack_seen <= 1'b0;
      len_flag <= 1'b0;
      out_valid <= 1'b0;
      out_start <= 1'b0;
      out_end <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      gap_cnt <= inj_done ? 8'd0 : (from_main && main_acc && main_end && gap_cnt != 8'hFF) ? gap_cnt + 8'd1 : gap_cnt;
      tmr <= state == S_INJ_REQ ? tmr + 8'd1 : 8'd0;
      wcnt <= inj_acc ? wcnt_n : wcnt;
      ack_seen <= state == S_INJ && !inj_done && (ack_seen || inj_ack);
      len_flag <= !inj_done && (len_flag || len_bad);
      out_valid <= fwd;
      out_start <= fwd && (from_main ? main_start : inj_start);
      out_end <= fwd && (from_main ? main_end : inj_end);
      out_data <= !fwd ? '0 : from_main ? main_data : inj_data;
    end
  ts_inject_mux_stat u_stat (
    .payload_clk(payload_clk),
    .payload_rst_n(payload_rst_n),
    .inj_done(inj_done),
    .drop_done(drop_done),
    .timeout(timeout),
    .len_bad(len_bad),
    .inj_pkt_cnt(inj_pkt_cnt),
    .drop_cnt(drop_cnt),
    .err_timeout(err_timeout),
    .err_len(err_len)
  );
endmodule

// File: tb/tb_ts_inject_mux.sv
// tb_ts_inject_mux: randomized packet-level scoreboard bench for ts_inject_mux
module tb_ts_inject_mux;
  logic payload_clk, payload_rst_n;
  logic main_valid, main_start, main_end, main_ready;
  logic [31:0] main_data, inj_data, out_data;
  logic inj_pending, inj_req, inj_ack, inj_valid, inj_start, inj_end;
  logic [7:0] cfg_min_gap;
  logic cfg_null_drop, out_valid, out_start, out_end, err_timeout, err_len;
  logic [15:0] inj_pkt_cnt, drop_cnt;
  ts_inject_mux dut (
    .payload_clk(payload_clk), .payload_rst_n(payload_rst_n),
    .main_valid(main_valid), .main_start(main_start), .main_end(main_end), .main_data(main_data),
    .main_ready(main_ready), .inj_pending(inj_pending), .inj_req(inj_req), .inj_ack(inj_ack),
    .inj_valid(inj_valid), .inj_start(inj_start), .inj_end(inj_end), .inj_data(inj_data),
    .cfg_min_gap(cfg_min_gap), .cfg_null_drop(cfg_null_drop),
    .out_valid(out_valid), .out_start(out_start), .out_end(out_end), .out_data(out_data),
    .inj_pkt_cnt(inj_pkt_cnt), .drop_cnt(drop_cnt), .err_timeout(err_timeout), .err_len(err_len)
  );
  logic [33:0] mq[$], iw[$], exp_q[$];
  logic [33:0] e;
  logic ack_prev, main_en, silent, force_pend;
  int vectors, miscompares, cyc, gap_m, inj_exp, drop_exp, len_exp, to_exp, len_seen, to_seen;
  initial begin
    payload_clk = 0;
    forever #5 payload_clk = ~payload_clk;
  end
  always @(posedge payload_clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  always @(negedge payload_clk)
    if (payload_rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 64'(out_valid), 0);
        else begin
          e = exp_q.pop_front();
          chk("out_word", {out_start, out_end, out_data}, e);
        end
      end else chk("out_idle", {out_start, out_end, out_data}, 0);
      if (ack_prev) chk("req_after_ack", 64'(inj_req), 0);
      ack_prev = inj_valid && inj_ack;
      if (err_len) len_seen++;
      if (err_timeout) to_seen++;
    end
  initial begin
    inj_pending = 0;
    forever begin
      @(posedge payload_clk);
      #1 inj_pending = iw.size() > 0 || force_pend;
    end
  end
  initial begin
    logic acc;
    main_valid = 0; main_start = 0; main_end = 0; main_data = 0;
    forever begin
      @(negedge payload_clk);
      acc = main_valid && main_ready;
      @(posedge payload_clk);
      #1;
      if (acc) void'(mq.pop_front());
      if (main_en && mq.size() > 0 && $urandom_range(0, 4) != 0) {main_start, main_end, main_data} = mq[0];
      else {main_start, main_end, main_data} = {2'b00, 32'($urandom)};
      main_valid = main_en && mq.size() > 0 && (main_start || main_data != 0 || 1'b1) && main_data === main_data && (mq.size() > 0 ? {main_start, main_end, main_data} == mq[0] : 1'b0);
    end
  end
  initial begin
    logic [33:0] w;
    logic done, started;
    inj_valid = 0; inj_start = 0; inj_end = 0; inj_ack = 0; inj_data = 0;
    forever begin
      @(negedge payload_clk);
      if (inj_req && !silent && iw.size() > 0) begin
        repeat ($urandom_range(0, 3)) @(posedge payload_clk);
        done = 0;
        started = 0;
        while (!done) begin
          @(posedge payload_clk);
          #1;
          if (started && $urandom_range(0, 5) == 0) begin
            {inj_valid, inj_start, inj_end, inj_ack, inj_data} = {4'b0000, 32'($urandom)};
          end else begin
            w = iw.pop_front();
            {inj_start, inj_end, inj_data} = w;
            inj_valid = 1;
            inj_ack = w[32];
            started = 1;
            done = w[32];
          end
        end
        @(posedge payload_clk);
        #1 {inj_valid, inj_start, inj_end, inj_ack, inj_data} = '0;
      end
    end
  end
  task automatic push_main(int len, bit is_null, bit dropped);
    logic [12:0] pid;
    logic [31:0] d;
    logic [33:0] w;
    if ($urandom_range(0, 9) == 0) mq.push_back({2'b00, 32'($urandom)});
    pid = 13'($urandom_range(0, 8190));
    for (int k = 0; k < len; k++) begin
      d = k != 0 ? 32'($urandom) : is_null ? 32'h471FFF10 : {8'h47, 3'($urandom), pid, 8'($urandom)};
      w = {k == 0, k == len - 1, d};
      mq.push_back(w);
      if (!dropped) exp_q.push_back(w);
    end
    if (dropped) drop_exp++;
    else if (gap_m < 255) gap_m++;
  endtask
  task automatic push_inj(int len, bit seq);
    logic [33:0] w;
    for (int k = 0; k < len; k++) begin
      w = {k == 0, k == len - 1, seq ? 32'(k + 1) : 32'($urandom)};
      iw.push_back(w);
      exp_q.push_back(w);
    end
    inj_exp++;
    gap_m = 0;
    if (len != 48) len_exp++;
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge payload_clk);
      ok = mq.size() == 0 && iw.size() == 0 && exp_q.size() == 0 && !inj_valid;
    end
    chk("drain", 64'(ok), 1);
    repeat (4) @(negedge payload_clk);
  endtask
  task automatic check_counts();
    chk("inj_pkt_cnt", 64'(inj_pkt_cnt), 64'(16'(inj_exp)));
    chk("drop_cnt", 64'(drop_cnt), 64'(16'(drop_exp)));
    chk("err_len_pulses", 64'(len_seen), 64'(len_exp));
    chk("err_timeout_pulses", 64'(to_seen), 64'(to_exp));
  endtask
  task automatic run_phase(int nmain, int ninj, int gcfg, bit drop, int null_pct);
    int mi = 0, ij = 0;
    bit nl, flush, ok;
    @(posedge payload_clk);
    #1;
    main_en = 0;
    cfg_min_gap = 8'(gcfg);
    cfg_null_drop = drop;
    while (mi < nmain || ij < ninj) begin
      if (ij < ninj && gap_m >= gcfg) begin
        push_inj(48, 0);
        ij++;
      end else if (mi < nmain) begin
        nl = $urandom_range(0, 99) < null_pct;
        push_main($urandom_range(2, 8), nl, drop && nl);
        mi++;
      end else break;
    end
    flush = ij < ninj;
    for (; ij < ninj; ij++) push_inj(48, 0);
    repeat (3) @(posedge payload_clk);
    #1 main_en = 1;
    if (flush) begin
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
        @(negedge payload_clk);
        ok = mq.size() == 0;
      end
      chk("main_drain", 64'(ok), 1);
      repeat (10) @(posedge payload_clk);
      #1 cfg_min_gap = 0;
    end
    wait_idle();
    check_counts();
  endtask
  initial begin
    bit ok;
    int t0;
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int t0;
    payload_rst_n = 0;
    cfg_min_gap = 0; cfg_null_drop = 0;
    main_en = 0; silent = 0; force_pend = 0; ack_prev = 0;
    gap_m = 255;
    repeat (3) @(posedge payload_clk);
    @(negedge payload_clk);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_main_ready", 64'(main_ready), 0);
    chk("rst_inj_req", 64'(inj_req), 0);
    chk("rst_inj_pkt_cnt", 64'(inj_pkt_cnt), 0);
    chk("rst_drop_cnt", 64'(drop_cnt), 0);
    chk("rst_err_timeout", 64'(err_timeout), 0);
    chk("rst_err_len", 64'(err_len), 0);
    payload_rst_n = 1;
    @(posedge payload_clk);
    #1 push_inj(48, 1);
    wait_idle();
    check_counts();
    run_phase(8, 3, 2, 0, 0);
    run_phase(1, 0, 0, 1, 100);
    run_phase(1, 0, 0, 0, 100);
    @(posedge payload_clk);
    #1;
    main_en = 0; cfg_min_gap = 0; silent = 1; force_pend = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge payload_clk);
      ok = inj_req;
    end
    chk("req_rise", 64'(ok), 1);
    t0 = cyc;
    force_pend = 0;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge payload_clk);
      ok = err_timeout;
    end
    chk("timeout_seen", 64'(ok), 1);
    chk("timeout_delay", 64'(cyc - t0), 255);
    chk("timeout_req_drop", 64'(inj_req), 0);
    silent = 0;
    to_exp++;
    @(posedge payload_clk);
    #1 push_main(4, 0, 0);
    main_en = 1;
    wait_idle();
    check_counts();
    @(posedge payload_clk);
    #1 push_inj(47, 0);
    push_inj(50, 0);
    wait_idle();
    check_counts();
    @(posedge payload_clk);
    #1 main_en = 0;
    cfg_null_drop = 0;
    push_main(8, 0, 0);
    main_en = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge payload_clk);
      ok = out_valid;
    end
    chk("contention_main_start", 64'(ok), 1);
    @(posedge payload_clk);
    #1 push_inj(48, 0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge payload_clk);
      chk("contention_req_held", 64'(inj_req), 0);
      ok = out_valid && out_end;
    end
    chk("contention_main_end", 64'(ok), 1);
    wait_idle();
    check_counts();
    for (int p = 0; p < 8; p++)
      run_phase($urandom_range(2, 10), $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
